// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NO_OP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries; flush overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    // A pop frees the slot the simultaneous push lands in.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Instruction-fetch initiator pairing one-cycle-late grants
//               with their PC and buffering (pc, instr) for the core.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic [31:0] instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] fetch_count_o,
    output logic        error_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic         r_req;
    logic [31:0]  r_addr;
    logic         r_inflight;
    logic [31:0]  r_inflight_pc;
    logic         r_squash;
    logic         r_err_mask;
    logic [31:0]  r_fetch_count;
    logic         r_error;

    logic [CW-1:0] w_count;
    logic [OW-1:0] w_occ;
    logic          w_full;
    logic          w_empty;
    logic          w_free;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_wr;
    fetch_entry_t  w_head;

    // Slots are reserved for both the presented request and the one awaiting its grant.
    assign w_occ  = OW'(w_count) + OW'(r_req) + OW'(r_inflight);
    assign w_free = !w_full && (w_occ < OW'(FIFO_DEPTH));

    assign w_push = instr_gnt_i && r_inflight && !r_squash && !redirect_i;
    assign w_pop  = !w_empty && out_ready_i && !redirect_i;
    assign w_wr   = '{pc: r_inflight_pc, instr: instr_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (redirect_i),
        .wr_data (w_wr),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        if (!enable_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:  w_state_nxt = RUN;
                RUN: begin
                    if (w_free) begin
                        w_issue = !redirect_i;
                    end else begin
                        w_state_nxt = STALL;
                    end
                end
                STALL: begin
                    if (w_free) begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_pc          <= BOOT_ADDR;
            r_req         <= 1'b0;
            r_addr        <= BOOT_ADDR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_squash      <= 1'b0;
            r_err_mask    <= 1'b1;
            r_fetch_count <= '0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_issue;
            r_inflight    <= r_req;
            r_inflight_pc <= r_addr;
            r_squash      <= redirect_i;
            r_err_mask    <= 1'b0;
            if (redirect_i) begin
                r_pc <= redirect_addr_i & ~32'h3;
            end else if (w_issue) begin
                r_addr <= r_pc;
                r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (instr_gnt_i && !r_inflight && !r_err_mask) begin
                r_error <= 1'b1;
            end
        end
    end

    assign instr_req_o   = r_req;
    assign instr_addr_o  = r_addr;
    assign out_valid_o   = !w_empty;
    assign out_instr_o   = w_empty ? NO_OP : w_head.instr;
    assign out_pc_o      = w_empty ? 32'h0 : w_head.pc;
    assign fetch_count_o = r_fetch_count;
    assign error_o       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Directed, table-driven bench for instr_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0010_0093;
    localparam logic [31:0] I4  = 32'h0020_0113;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        mem_gnt = 1'b0;
    logic        spur = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fcount;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .BOOT_ADDR  (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .instr_req_o     (req),
        .instr_addr_o    (addr),
        .instr_gnt_i     (gnt),
        .instr_i         (mem_rdata),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .out_valid_o     (valid),
        .out_ready_i     (ready),
        .out_instr_o     (out_instr),
        .out_pc_o        (out_pc),
        .fetch_count_o   (fcount),
        .error_o         (err)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return I0;
        if (a == 32'h4) return I4;
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // One-cycle memory: grant and data follow the registered request.
    always @(posedge clk) begin
        mem_gnt   <= req;
        mem_rdata <= word(addr);
    end
    assign gnt = mem_gnt | spur;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [31:0] raddr;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic rdy, input logic redir,
                       input logic [31:0] raddr, input logic xreq,
                       input logic [31:0] xaddr, input logic xvalid,
                       input logic [31:0] xpc, input logic [31:0] xinstr,
                       input logic [31:0] xcnt);
        vec_t v;
        v = '{en, rdy, redir, raddr, xreq, xaddr, xvalid, xpc, xinstr, xcnt};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req"},   32'(req), 32'h0);
        chk({tag, ".addr"},  addr, 32'h0);
        chk({tag, ".valid"}, 32'(valid), 32'h0);
        chk({tag, ".instr"}, out_instr, NOP);
        chk({tag, ".pc"},    out_pc, 32'h0);
        chk({tag, ".cnt"},   fcount, 32'h0);
        chk({tag, ".err"},   32'(err), 32'h0);
    endtask

    initial begin
        int nreq;

        //  en rdy rd raddr  | req addr   vld pc     instr                cnt
        add(1, 1, 0, 0,       0, 32'h00, 0, 32'h00, NOP,                 0);
        add(1, 1, 0, 0,       1, 32'h00, 0, 32'h00, NOP,                 0);
        add(1, 1, 0, 0,       1, 32'h04, 0, 32'h00, NOP,                 0);
        add(1, 1, 0, 0,       1, 32'h08, 1, 32'h00, I0,                  0);
        add(1, 1, 0, 0,       1, 32'h0C, 1, 32'h04, I4,                  1);
        add(1, 1, 0, 0,       1, 32'h10, 1, 32'h08, 32'hC0DE0008,        2);
        add(1, 0, 0, 0,       1, 32'h14, 1, 32'h08, 32'hC0DE0008,        2);
        add(1, 0, 0, 0,       0, 32'h14, 1, 32'h08, 32'hC0DE0008,        2);
        add(1, 0, 0, 0,       0, 32'h14, 1, 32'h08, 32'hC0DE0008,        2);
        add(1, 0, 0, 0,       0, 32'h14, 1, 32'h08, 32'hC0DE0008,        2);
        add(1, 1, 0, 0,       0, 32'h14, 1, 32'h0C, 32'hC0DE000C,        3);
        add(1, 1, 0, 0,       0, 32'h14, 1, 32'h10, 32'hC0DE0010,        4);
        add(1, 1, 0, 0,       1, 32'h18, 1, 32'h14, 32'hC0DE0014,        5);
        add(1, 1, 0, 0,       1, 32'h1C, 0, 32'h00, NOP,                 6);
        add(1, 1, 0, 0,       1, 32'h20, 1, 32'h18, 32'hC0DE0018,        6);
        add(1, 1, 1, 32'h43,  0, 32'h20, 0, 32'h00, NOP,                 6);
        add(1, 1, 0, 0,       1, 32'h40, 0, 32'h00, NOP,                 6);
        add(1, 1, 0, 0,       1, 32'h44, 0, 32'h00, NOP,                 6);
        add(1, 1, 0, 0,       1, 32'h48, 1, 32'h40, 32'hC0DE0040,        6);
        add(1, 1, 0, 0,       1, 32'h4C, 1, 32'h44, 32'hC0DE0044,        7);
        add(0, 0, 0, 0,       0, 32'h4C, 1, 32'h44, 32'hC0DE0044,        7);
        add(0, 0, 0, 0,       0, 32'h4C, 1, 32'h44, 32'hC0DE0044,        7);
        add(0, 1, 0, 0,       0, 32'h4C, 1, 32'h48, 32'hC0DE0048,        8);
        add(0, 1, 0, 0,       0, 32'h4C, 1, 32'h4C, 32'hC0DE004C,        9);
        add(0, 1, 0, 0,       0, 32'h4C, 0, 32'h00, NOP,                 10);

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        rst = 1'b0;
        foreach (vecs[i]) begin
            enable        = vecs[i].en;
            ready         = vecs[i].rdy;
            redirect      = vecs[i].redir;
            redirect_addr = vecs[i].raddr;
            tick();
            chk($sformatf("row%0d.req", i),   32'(req), 32'(vecs[i].req));
            chk($sformatf("row%0d.addr", i),  addr, vecs[i].addr);
            chk($sformatf("row%0d.valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("row%0d.pc", i),    out_pc, vecs[i].pc);
            chk($sformatf("row%0d.instr", i), out_instr, vecs[i].instr);
            chk($sformatf("row%0d.cnt", i),   fcount, vecs[i].cnt);
            chk($sformatf("row%0d.err", i),   32'(err), 32'h0);
        end
        redirect = 1'b0;
        enable   = 1'b0;
        ready    = 1'b0;

        // Spurious grant with nothing outstanding sets a sticky error, pushes nothing.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur.err", 32'(err), 32'h1);
        chk("spur.valid", 32'(valid), 32'h0);
        repeat (3) tick();
        chk("spur.err_sticky", 32'(err), 32'h1);
        chk("spur.valid_later", 32'(valid), 32'h0);
        chk("spur.cnt", fcount, 32'd10);

        // With the core stalled, exactly FIFO_DEPTH requests go out.
        rst = 1'b1;
        tick();
        chk("rst2.err", 32'(err), 32'h0);
        rst    = 1'b0;
        enable = 1'b1;
        ready  = 1'b0;
        nreq   = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (req) begin
                chk($sformatf("stall.addr%0d", nreq), addr, 32'(4 * nreq));
                nreq++;
            end
        end
        chk("stall.nreq", 32'(nreq), 32'd4);
        chk("stall.req_low", 32'(req), 32'h0);
        chk("stall.head_pc", out_pc, 32'h0);
        chk("stall.head_instr", out_instr, I0);

        // Reset with buffered entries and a request outstanding.
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst    = 1'b0;
        enable = 1'b1;
        repeat (5) tick();
        chk("pre_rst.req", 32'(req), 32'h1);
        chk("pre_rst.addr", addr, 32'h0C);
        chk("pre_rst.valid", 32'(valid), 32'h1);
        rst = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        rst    = 1'b0;
        enable = 1'b0;
        tick();
        chk("post_rst.err", 32'(err), 32'h0);
        chk("post_rst.valid", 32'(valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
